mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mdu_pkg.sv | 27 ++
 rtl/mdu_shift_core.sv | 63 ++++++
 rtl/mult_div_unit.sv | 145 ++++++++++++++
 tb/tb_mult_div_unit.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encoding, FSM states
// and the divide-by-zero quotient fill.
package mdu_pkg;

    localparam logic [1:0] OP_MULT  = 2'd0;
    localparam logic [1:0] OP_MULTU = 2'd1;
    localparam logic [1:0] OP_DIV   = 2'd2;
    localparam logic [1:0] OP_DIVU  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    // Every LO bit takes this value after a divide by zero.
    localparam logic DIV_ZERO_LO_BIT = 1'b1;

    function automatic logic op_is_div(input logic [1:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/mdu_shift_core.sv
// Iterative datapath: one unsigned shift-add (multiply) or restoring
// shift-subtract (divide, only when MDU_DIV_EN is defined) step per cycle.
module mdu_shift_core
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             load,
    input  logic             step,
`ifdef MDU_DIV_EN
    input  logic             is_div,
`endif
    input  logic [WIDTH-1:0] a_abs,
    input  logic [WIDTH-1:0] b_abs,
    output logic [WIDTH-1:0] next_hi,
    output logic [WIDTH-1:0] next_lo
);

    // acc is the running upper half / partial remainder; low starts as the
    // multiplier or dividend and shifts out one bit per step.
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] low;
    logic [WIDTH-1:0] operand;
    logic [WIDTH:0]   sum;
`ifdef MDU_DIV_EN
    logic [WIDTH:0]   shifted;
    logic             ge;
    logic [WIDTH-1:0] diff;
`endif

    // NOTE: every output of a combinational block gets a value on every path
    // (defaults first), otherwise synthesis infers latches.
    always_comb begin
        sum     = {1'b0, acc} + (low[0] ? {1'b0, operand} : '0);
        next_hi = sum[WIDTH:1];
        next_lo = {sum[0], low[WIDTH-1:1]};
`ifdef MDU_DIV_EN
        shifted = {acc, low[WIDTH-1]};
        ge      = shifted >= {1'b0, operand};
        // Modular difference is exact whenever ge holds, since it is below operand.
        diff    = shifted[WIDTH-1:0] - operand;
        if (is_div) begin
            next_hi = ge ? diff : shifted[WIDTH-1:0];
            next_lo = {low[WIDTH-2:0], ge};
        end
`endif
    end

    // NOTE: pure datapath registers carry no reset; they are always loaded
    // before use and the FSM never commits them unless a full run completes.
    always_ff @(posedge clk) begin
        if (load) begin
            acc     <= '0;
            low     <= a_abs;
            operand <= b_abs;
        end else if (step) begin
            acc <= next_hi;
            low <= next_lo;
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO.
// Divide is built only when MDU_DIV_EN is defined; otherwise DIV/DIVU complete at once with no effect.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_hi,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             neg_res;
`ifdef MDU_DIV_EN
    logic             div_op;
    logic             neg_rem;
    logic             div_zero;
    logic [WIDTH-1:0] dividend;
`endif

    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_abs;
    logic [WIDTH-1:0]   b_abs;
    logic [WIDTH-1:0]   core_hi;
    logic [WIDTH-1:0]   core_lo;
    logic [WIDTH-1:0]   fin_hi;
    logic [WIDTH-1:0]   fin_lo;
    logic [2*WIDTH-1:0] prod;
    logic               load;
    logic               step;

    assign a_neg  = op_is_signed(op) && opA[WIDTH-1];
    assign b_neg  = op_is_signed(op) && opB[WIDTH-1];
    assign a_abs  = a_neg ? -opA : opA;
    assign b_abs  = b_neg ? -opB : opB;
    assign load   = (state == ST_IDLE) && start;
    assign step   = (state == ST_RUN);
    assign result = rd_hi ? hi : lo;

    mdu_shift_core #(.WIDTH(WIDTH)) u_core (
        .clk     (clk),
        .load    (load),
        .step    (step),
`ifdef MDU_DIV_EN
        .is_div  (div_op),
`endif
        .a_abs   (a_abs),
        .b_abs   (b_abs),
        .next_hi (core_hi),
        .next_lo (core_lo)
    );

    // Sign fix-up of the final step, committed to HI/LO on the DONE entry edge.
    always_comb begin
        prod   = {core_hi, core_lo};
        if (neg_res) prod = -prod;
        fin_hi = prod[2*WIDTH-1:WIDTH];
        fin_lo = prod[WIDTH-1:0];
`ifdef MDU_DIV_EN
        if (div_op) begin
            if (div_zero) begin
                fin_hi = dividend;
                fin_lo = {WIDTH{DIV_ZERO_LO_BIT}};
            end else begin
                fin_hi = neg_rem ? -core_hi : core_hi;
                fin_lo = neg_res ? -core_lo : core_lo;
            end
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            count <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (wr_hi) hi <= wr_data;
                    if (wr_lo) lo <= wr_data;
                    if (start) begin
                        neg_res <= a_neg ^ b_neg;
                        count   <= '0;
`ifdef MDU_DIV_EN
                        div_op   <= op_is_div(op);
                        neg_rem  <= a_neg;
                        div_zero <= (opB == '0);
                        dividend <= opA;
                        state    <= ST_RUN;
                        busy     <= 1'b1;
`else
                        if (op_is_div(op)) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_RUN;
                            busy  <= 1'b1;
                        end
`endif
                    end
                end
                ST_RUN: begin
                    count <= count + 1'b1;
                    if (count == LAST_STEP) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        hi    <= fin_hi;
                        lo    <= fin_lo;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit; the divide section follows
// the MDU_DIV_EN build option.
module tb_mult_div_unit;

    localparam int W = 32;
    localparam int LAT = W + 1;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] opA;
    logic [W-1:0] opB;
    logic         wr_hi;
    logic         wr_lo;
    logic [W-1:0] wr_data;
    logic         rd_hi;
    logic         busy;
    logic         done;
    logic [W-1:0] result;

    int checks   = 0;
    int failures = 0;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .opA     (opA),
        .opB     (opB),
        .wr_hi   (wr_hi),
        .wr_lo   (wr_lo),
        .wr_data (wr_data),
        .rd_hi   (rd_hi),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_hilo(output logic [W-1:0] h, output logic [W-1:0] l);
        rd_hi = 1'b1;
        #1 h = result;
        rd_hi = 1'b0;
        #1 l = result;
    endtask

    task automatic check_hilo(input string tag, input logic [W-1:0] eh, input logic [W-1:0] el);
        logic [W-1:0] h, l;
        read_hilo(h, l);
        check({tag, " HI"}, 64'(h), 64'(eh));
        check({tag, " LO"}, 64'(l), 64'(el));
    endtask

    // Called in cycle 1; returns in the done cycle (or after the bound).
    task automatic wait_done(input string tag, input int exp_lat);
        int cyc = 1;
        int nbusy = 0;
        while (!done && cyc < 200) begin
            if (busy) nbusy++;
            tick();
            cyc++;
        end
        check({tag, " latency"}, 64'(cyc), 64'(exp_lat));
        check({tag, " busy cycles"}, 64'(nbusy), 64'(exp_lat - 1));
        check({tag, " busy at done"}, 64'(busy), 64'(0));
    endtask

    task automatic do_op(input string tag, input logic [1:0] o, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] eh,
                         input logic [W-1:0] el, input int exp_lat);
        op = o; opA = a; opB = b; start = 1'b1;
        tick();
        start = 1'b0;
        opA = 32'hA5A5_0F0F;
        opB = 32'h0000_0001;
        wait_done(tag, exp_lat);
        check_hilo(tag, eh, el);
        tick();
        check({tag, " done width"}, 64'(done), 64'(0));
    endtask

    task automatic mt_write(input logic h, input logic [W-1:0] d);
        wr_hi = h; wr_lo = !h; wr_data = d;
        tick();
        wr_hi = 1'b0; wr_lo = 1'b0;
    endtask

    initial begin
        int ndone;
        int nbusy;
        logic [W-1:0] h, l;

        reset = 1'b1; start = 1'b0; op = 2'd0; opA = '0; opB = '0;
        wr_hi = 1'b0; wr_lo = 1'b0; wr_data = '0; rd_hi = 1'b0;
        tick(); tick();
        check("reset busy", 64'(busy), 64'(0));
        check("reset done", 64'(done), 64'(0));
        check_hilo("reset", 32'h0, 32'h0);
        reset = 1'b0;
        tick();

        do_op("multu ffffffff*2", 2'd1, 32'hFFFF_FFFF, 32'h2, 32'h1, 32'hFFFF_FFFE, LAT);
        do_op("mult -7*3", 2'd0, 32'hFFFF_FFF9, 32'h3, 32'hFFFF_FFFF, 32'hFFFF_FFEB, LAT);
        do_op("mult -2*-3", 2'd0, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0, 32'h6, LAT);
        do_op("mult min*min", 2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, LAT);
        do_op("multu max*max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, LAT);
        do_op("mult -1*maxpos", 2'd0, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001, LAT);

        mt_write(1'b1, 32'h77);
        mt_write(1'b0, 32'h66);
        check_hilo("mthi mtlo", 32'h77, 32'h66);

        // start held high throughout: re-requests in RUN and DONE must be ignored
        op = 2'd1; opA = 32'd5; opB = 32'd6; start = 1'b1;
        tick();
        tick(); tick();
        wr_hi = 1'b1; wr_data = 32'hDEAD;
        tick();
        wr_hi = 1'b0;
        check_hilo("mt during run", 32'h77, 32'h66);
        ndone = 0;
        nbusy = 4;
        while (!done && nbusy < 200) begin
            tick();
            nbusy++;
        end
        check("held start latency", 64'(nbusy), 64'(LAT));
        wr_lo = 1'b1; wr_data = 32'hBEEF;
        tick();
        start = 1'b0; wr_lo = 1'b0;
        check("start in done busy", 64'(busy), 64'(0));
        check("start in done pulse", 64'(done), 64'(0));
        check_hilo("mt during done", 32'h0, 32'd30);

        // MTLO together with start: write lands first, result overwrites it
        op = 2'd1; opA = 32'd2; opB = 32'd3; start = 1'b1; wr_lo = 1'b1; wr_data = 32'h999;
        tick();
        start = 1'b0; wr_lo = 1'b0;
        check_hilo("start+mtlo write", 32'h0, 32'h999);
        wait_done("start+mtlo", LAT);
        check_hilo("start+mtlo result", 32'h0, 32'h6);
        tick();

        // Abort a running multiply with reset
        mt_write(1'b1, 32'h33);
        op = 2'd1; opA = 32'd3; opB = 32'd4; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 5; c++) tick();
        start = 1'b1; wr_hi = 1'b1; wr_data = 32'h55;
        tick();
        start = 1'b0; wr_hi = 1'b0;
        for (int c = 6; c < 10; c++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort busy", 64'(busy), 64'(0));
        check_hilo("abort", 32'h0, 32'h0);
        ndone = 0;
        nbusy = 0;
        for (int c = 0; c < 40; c++) begin
            if (done) ndone++;
            if (busy) nbusy++;
            tick();
        end
        check("abort done pulses", 64'(ndone), 64'(0));
        check("abort busy cycles", 64'(nbusy), 64'(0));
        rd_hi = 1'b0; wr_lo = 1'b1; wr_data = 32'h1234;
        tick();
        wr_lo = 1'b0;
        check("mtlo after abort", 64'(result), 64'(32'h1234));

`ifdef MDU_DIV_EN
        do_op("div -7/2", 2'd2, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, LAT);
        do_op("divu 7/0", 2'd3, 32'h7, 32'h0, 32'h7, 32'hFFFF_FFFF, LAT);
        do_op("div overflow", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, LAT);
        do_op("divu 100/7", 2'd3, 32'd100, 32'd7, 32'd2, 32'd14, LAT);
        do_op("div 7/-2", 2'd2, 32'h7, 32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFD, LAT);
        do_op("div -8/0", 2'd2, 32'hFFFF_FFF8, 32'h0, 32'hFFFF_FFF8, 32'hFFFF_FFFF, LAT);
`else
        mt_write(1'b1, 32'hA);
        do_op("div disabled 9/3", 2'd2, 32'd9, 32'd3, 32'hA, 32'h1234, 1);
        do_op("divu disabled 7/0", 2'd3, 32'd7, 32'd0, 32'hA, 32'h1234, 1);
`endif

        read_hilo(h, l);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
